bus_router: RTL

Parametrised CPU-to-slave memory-bus router replacing the fixed three-way address mux in the top level. It decodes each CPU request against NUM_SLAVES address ranges and latches the selected slave for the whole transaction. It forwards the request strobe only to that slave and returns its read data and completion strobe. It also provides a bus-error response for unmapped addresses and for slaves that never answer (timeout).

---
 rtl/bus_pkg.sv | 34 +++
 rtl/bus_addr_decode.sv | 43 ++++
 rtl/bus_router.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-to-slave memory-bus router and its address
// decoder. Provides the router state type, the default error read data,
// the slave-count bound and small sizing/range helper functions.
package bus_pkg;

    localparam int unsigned MAX_SLAVES       = 8;
    localparam int unsigned MAX_ADDR_W       = 64;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ERR,
        RELEASE
    } state_t;

    // Width of a slave index; a single-slave router still needs one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must be able to hold the value timeout.
    function automatic int unsigned ctr_width(input int unsigned timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

    // Inclusive range test on zero-extended address values.
    function automatic logic in_range(input logic [MAX_ADDR_W-1:0] a,
                                      input logic [MAX_ADDR_W-1:0] base,
                                      input logic [MAX_ADDR_W-1:0] limit);
        return (a >= base) && (a <= limit);
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Purely combinational address decoder: maps an address onto one of
// NUM_SLAVES inclusive ranges. The lowest-index matching range wins.
// Ports:
//   address  in   ADDR_W  address to decode
//   hit      out  1       some range contains address
//   sel      out  SEL_W   index of the winning range (0 when no hit)
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int unsigned                    NUM_SLAVES = 3,
    parameter int unsigned                    ADDR_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_BASE   = {32'h8000_0000, 32'h0003_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_LIMIT  = {32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0002_FFFF},
    parameter int unsigned                    SEL_W      = sel_width(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0] address,
    output logic              hit,
    output logic [SEL_W-1:0]  sel
);

    if (NUM_SLAVES < 1 || NUM_SLAVES > MAX_SLAVES) begin : g_bad_count
        $error("bus_addr_decode: NUM_SLAVES out of range");
    end
    if (ADDR_W > MAX_ADDR_W) begin : g_bad_width
        $error("bus_addr_decode: ADDR_W too wide");
    end

    always_comb begin
        hit = 1'b0;
        sel = '0;
        // Ascending scan; the first hit blocks later ones, giving priority
        // to the lowest index on overlapping ranges.
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && in_range(MAX_ADDR_W'(address),
                                 MAX_ADDR_W'(SLV_BASE[i*ADDR_W +: ADDR_W]),
                                 MAX_ADDR_W'(SLV_LIMIT[i*ADDR_W +: ADDR_W]))) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_router.sv
// Parametrised CPU-to-slave memory-bus router. Decodes each request against
// NUM_SLAVES address ranges, latches the selected slave for the whole
// transaction, gates the request strobe to that slave only and returns its
// read data and completion. Unmapped addresses and timed-out slaves get a
// one-cycle error completion carrying ERR_DATA and set a sticky error flag.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   address, rw_req     CPU address and level request (held until rec)
//   rw, write_data,size CPU write path, broadcast unregistered
//   read_data, rec      returned data and one-cycle completion
//   s_rw_req            per-slave gated request
//   s_read_data         packed per-slave read data
//   s_data_valid        per-slave completion
//   s_address, s_rw,    broadcast copies of the CPU address/write path
//   s_write_data,s_size
//   bus_err, err_clr    sticky error flag and its clear
//   err_addr            address of the first error since the last clear
module bus_router
    import bus_pkg::*;
#(
    parameter int unsigned                    NUM_SLAVES = 3,
    parameter int unsigned                    ADDR_W     = 32,
    parameter int unsigned                    DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_BASE   = {32'h8000_0000, 32'h0003_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_LIMIT  = {32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0002_FFFF},
    parameter int unsigned                    TIMEOUT    = 1023,
    parameter logic [DATA_W-1:0]              ERR_DATA   = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            address,
    input  logic                         rw_req,
    input  logic                         rw,
    input  logic [DATA_W-1:0]            write_data,
    input  logic [1:0]                   size,
    output logic [DATA_W-1:0]            read_data,
    output logic                         rec,
    output logic [NUM_SLAVES-1:0]        s_rw_req,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_read_data,
    input  logic [NUM_SLAVES-1:0]        s_data_valid,
    output logic [ADDR_W-1:0]            s_address,
    output logic                         s_rw,
    output logic [DATA_W-1:0]            s_write_data,
    output logic [1:0]                   s_size,
    output logic                         bus_err,
    input  logic                         err_clr,
    output logic [ADDR_W-1:0]            err_addr
);

    localparam int unsigned      SEL_W     = sel_width(NUM_SLAVES);
    localparam int unsigned      CNT_W     = ctr_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic             TMO_EN    = (TIMEOUT != 0);

    state_t            state;
    logic [SEL_W-1:0]  sel;
    logic [CNT_W-1:0]  cnt;
    logic              dec_hit;
    logic [SEL_W-1:0]  dec_sel;
    logic              sel_valid;
    logic              timed_out;

    bus_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_LIMIT  (SLV_LIMIT),
        .SEL_W      (SEL_W)
    ) u_decode (
        .address (address),
        .hit     (dec_hit),
        .sel     (dec_sel)
    );

    // Write path is not registered; every slave sees it, only the request
    // strobe is gated.
    assign s_address    = address;
    assign s_rw         = rw;
    assign s_write_data = write_data;
    assign s_size       = size;

    assign sel_valid = s_data_valid[sel];
    assign timed_out = TMO_EN && (cnt == CNT_LIMIT);

    // Response path is combinational from the latched state so that a slave
    // completion reaches rec in the same cycle.
    always_comb begin
        s_rw_req  = '0;
        rec       = 1'b0;
        read_data = ERR_DATA;
        case (state)
            BUSY: begin
                s_rw_req[sel] = rw_req;
                read_data     = s_read_data[sel*DATA_W +: DATA_W];
                rec           = sel_valid;
            end
            ERR: begin
                rec = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= '0;
            cnt      <= '0;
            bus_err  <= 1'b0;
            err_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rw_req) begin
                        if (dec_hit) begin
                            sel   <= dec_sel;
                            cnt   <= '0;
                            state <= BUSY;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                BUSY: begin
                    // A completion in the timeout cycle still counts as success.
                    if (sel_valid) begin
                        state <= RELEASE;
                    end else if (timed_out) begin
                        state <= ERR;
                    end
                    if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ERR: begin
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (!rw_req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A new error takes precedence over a simultaneous clear and then
            // records the new address.
            if (state == ERR) begin
                bus_err <= 1'b1;
                if (!bus_err || err_clr) begin
                    err_addr <= address;
                end
            end else if (err_clr) begin
                bus_err  <= 1'b0;
                err_addr <= '0;
            end
        end
    end

endmodule
